// File: rtl/ext_mem_responder_pkg.sv
// Shared types for the external-memory load responder.
// State encoding, size codes and the error response word.
package ext_mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_t;

    localparam logic [47:0] ERR_WORD = 48'hFFFF_FFFF_FFFF;

    function automatic logic [2:0] size_to_bytes(input size_t sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// CPU request/response handshake plus byte-wide external memory port.
// The slave side is the responder; the master side is CPU and memory.
interface ext_mem_responder_if #(
    parameter int ADDR_W = 16
);

    logic              ENABLE;
    logic [2:0]        CTRL;
    logic [47:0]       ADDRESS;
    logic [47:0]       READ;
    logic              HANDSHAKE;
    logic              ERROR;
    logic              BUSY;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_RE;
    logic [7:0]        MEM_RDATA;
    logic              MEM_VALID;

    modport slave (
        input  ENABLE, CTRL, ADDRESS, MEM_RDATA, MEM_VALID,
        output READ, HANDSHAKE, ERROR, BUSY, MEM_ADDR, MEM_RE
    );

    modport master (
        output ENABLE, CTRL, ADDRESS, MEM_RDATA, MEM_VALID,
        input  READ, HANDSHAKE, ERROR, BUSY, MEM_ADDR, MEM_RE
    );

endinterface

// File: rtl/ext_mem_responder_byte_gather.sv
// 48-bit little-endian lane register with lane-indexed byte load.
// Extension output is combinational from lanes, byte count and sign flag.
module byte_gather (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [2:0]  i_idx,
    input  logic [7:0]  i_byte,
    input  logic [2:0]  i_nbytes,
    input  logic        i_sign,
    output logic [47:0] o_ext
);

    logic [47:0] r_lanes;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_lanes <= '0;
        end else if (i_load) begin
            for (int k = 0; k < 6; k++) begin
                if (i_idx == 3'(k)) begin
                    r_lanes[8*k +: 8] <= i_byte;
                end
            end
        end
    end

    always_comb begin
        o_ext = r_lanes;
        case (i_nbytes)
            3'd1: o_ext = {{40{i_sign & r_lanes[7]}}, r_lanes[7:0]};
            3'd2: o_ext = {{32{i_sign & r_lanes[15]}}, r_lanes[15:0]};
            3'd4: o_ext = {{16{i_sign & r_lanes[31]}}, r_lanes[31:0]};
            default: o_ext = r_lanes;
        endcase
    end

endmodule

// File: rtl/ext_mem_responder.sv
// Serves CPU loads from a slow byte-wide external memory, one byte per
// ISSUE/WAIT round, then pulses HANDSHAKE and holds off re-acceptance.
module ext_mem_responder
    import ext_mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT     = 255,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    ext_mem_responder_if.slave  bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_sign;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_idx;
    logic [2:0]        r_nbytes;
    logic [7:0]        r_tcnt;
    logic [HW-1:0]     r_hcnt;
    logic              r_to;
    logic [47:0]       r_read;
    logic              r_hs;
    logic              r_error;
    logic              r_busy;
    logic              r_mem_re;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              w_last;
    logic              w_timeout;
    logic              w_accept;
    logic              w_load;
    logic [47:0]       w_ext;
    logic              w_unused_addr;

    assign w_accept      = (r_state == IDLE) && bus.ENABLE;
    assign w_load        = (r_state == WAIT) && bus.MEM_VALID;
    assign w_last        = (r_idx == r_nbytes - 3'd1);
    assign w_unused_addr = ^bus.ADDRESS[47:ADDR_W];

    byte_gather u_gather (
        .i_clk    (CLK),
        .i_rst    (RESET),
        .i_clr    (w_accept),
        .i_load   (w_load),
        .i_idx    (r_idx),
        .i_byte   (bus.MEM_RDATA),
        .i_nbytes (r_nbytes),
        .i_sign   (r_sign),
        .o_ext    (w_ext)
    );

    // Data wins over a timeout landing on the same edge.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:  if (bus.ENABLE) w_next = ISSUE;
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (bus.MEM_VALID) begin
                    w_next = w_last ? RESP : ISSUE;
                end else if (r_tcnt == TO_LAST) begin
                    w_next    = RESP;
                    w_timeout = 1'b1;
                end
            end
            RESP:  w_next = HOLD;
            HOLD:  if (r_hcnt == HOLD_LAST) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_base     <= '0;
            r_idx      <= '0;
            r_nbytes   <= '0;
            r_tcnt     <= '0;
            r_hcnt     <= '0;
            r_to       <= 1'b0;
            r_read     <= '0;
            r_hs       <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != IDLE);
            r_hs     <= 1'b0;
            r_mem_re <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.ENABLE) begin
                        r_sign   <= bus.CTRL[2];
                        r_base   <= bus.ADDRESS[ADDR_W-1:0];
                        r_idx    <= '0;
                        r_nbytes <= size_to_bytes(size_t'(bus.CTRL[1:0]));
                        r_to     <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_mem_re   <= 1'b1;
                    r_mem_addr <= r_base + ADDR_W'(r_idx);
                    r_tcnt     <= '0;
                end
                WAIT: begin
                    if (bus.MEM_VALID) begin
                        if (!w_last) r_idx <= r_idx + 3'd1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (w_timeout) r_to <= 1'b1;
                    end
                end
                RESP: begin
                    r_hs    <= 1'b1;
                    r_read  <= r_to ? ERR_WORD : w_ext;
                    r_error <= r_to;
                    r_hcnt  <= '0;
                end
                HOLD: r_hcnt <= r_hcnt + HW'(1);
                default: ;
            endcase
        end
    end

    assign bus.READ      = r_read;
    assign bus.HANDSHAKE = r_hs;
    assign bus.ERROR     = r_error;
    assign bus.BUSY      = r_busy;
    assign bus.MEM_RE    = r_mem_re;
    assign bus.MEM_ADDR  = r_mem_addr;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomized bench for ext_mem_responder with a byte-level memory
// model and a transaction-level reference for result and latency.
module tb_ext_mem_responder;

    localparam int TO   = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst;

    ext_mem_responder_if #(.ADDR_W(16)) bus ();

    ext_mem_responder #(
        .ADDR_W      (16),
        .TIMEOUT     (TO),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [65536];
    int          wv [6];
    int          wq [$];
    logic [15:0] re_q [$];
    bit          mem_mute = 1'b0;
    int          hs_cnt = 0;
    int          last_lat;

    logic [47:0] m_val;
    bit          m_err;
    int          m_lat;
    int          m_na;
    logic [15:0] m_addr [6];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte memory: answers each strobe after the queued number of wait cycles.
    initial begin
        bit          pend;
        logic [15:0] pa;
        int          dly;
        pend          = 1'b0;
        pa            = '0;
        dly           = 0;
        bus.MEM_VALID = 1'b0;
        bus.MEM_RDATA = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.MEM_VALID = 1'b0;
            if (bus.MEM_RE) begin
                pend = 1'b1;
                pa   = bus.MEM_ADDR;
                dly  = (wq.size() > 0) ? wq.pop_front() : 0;
            end
            if (pend && mem_mute) pend = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    bus.MEM_VALID = 1'b1;
                    bus.MEM_RDATA = mem[pa];
                    pend          = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.MEM_RE) re_q.push_back(bus.MEM_ADDR);
            if (bus.HANDSHAKE) hs_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // A byte costs ISSUE + WAITs; a wait of TO or more cycles times out.
    task automatic model(input logic [2:0] ctrl, input logic [47:0] addr);
        int n;
        n = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 :
            (ctrl[1:0] == 2'd2) ? 4 : 6;
        m_val = '0;
        m_err = 1'b0;
        m_lat = 1;
        m_na  = 0;
        for (int i = 0; i < n; i++) begin
            m_addr[i] = addr[15:0] + 16'(i);
            m_na++;
            if (wv[i] >= TO) begin
                m_err = 1'b1;
                m_lat += 1 + TO;
                break;
            end
            m_val |= 48'(mem[m_addr[i]]) << (8 * i);
            m_lat += 2 + wv[i];
        end
        if (m_err) m_val = '1;
        else if (ctrl[2] && n < 6 && m_val[8*n-1])
            m_val |= ~((48'd1 << (8 * n)) - 48'd1);
    endtask

    task automatic run_req(input logic [2:0] ctrl, input logic [47:0] addr,
                           input bit scramble);
        int lat;
        int hold_n;
        model(ctrl, addr);
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(wv[i]);
        @(negedge clk);
        re_q.delete();
        bus.CTRL    = ctrl;
        bus.ADDRESS = addr;
        bus.ENABLE  = 1'b1;
        @(posedge clk);
        #3;
        if (scramble) begin
            bus.CTRL    = 3'($urandom);
            bus.ADDRESS = 48'({$urandom, $urandom});
        end
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #3;
            if (bus.HANDSHAKE) begin
                lat = k;
                break;
            end
        end
        bus.ENABLE = 1'b0;
        last_lat   = lat;
        chk("latency", lat, m_lat);
        chk("read", bus.READ, m_val);
        chk("error", bus.ERROR, m_err);
        chk("busy_at_hs", bus.BUSY, 1'b1);
        chk("re_count", re_q.size(), m_na);
        for (int i = 0; i < m_na && i < re_q.size(); i++)
            chk("mem_addr", re_q[i], m_addr[i]);
        hold_n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #3;
            if (k == 1) chk("hs_pulse", bus.HANDSHAKE, 1'b0);
            if (!bus.BUSY) begin
                hold_n = k;
                break;
            end
        end
        chk("hold_len", hold_n, HOLD);
        chk("read_held", bus.READ, m_val);
        chk("error_held", bus.ERROR, m_err);
    endtask

    task automatic set_waits(input int w);
        for (int i = 0; i < 6; i++) wv[i] = w;
    endtask

    task automatic timeout_req(input logic [47:0] addr);
        mem_mute = 1'b1;
        set_waits(99);
        run_req(3'b010, addr, 1'b0);
        chk("to_lat", last_lat, 6);
        chk("to_read", bus.READ, 48'hFFFF_FFFF_FFFF);
        chk("to_err", bus.ERROR, 1'b1);
        mem_mute = 1'b0;
        set_waits(0);
    endtask

    initial begin
        int h1;
        int h2;
        int hs0;
        rst         = 1'b1;
        bus.ENABLE  = 1'b0;
        bus.CTRL    = '0;
        bus.ADDRESS = '0;
        set_waits(0);
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) @(posedge clk);
        #3;
        chk("rst_read", bus.READ, 48'h0);
        chk("rst_hs", bus.HANDSHAKE, 1'b0);
        chk("rst_err", bus.ERROR, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_mre", bus.MEM_RE, 1'b0);
        chk("rst_maddr", bus.MEM_ADDR, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) mem[16'h10 + 16'(i)] = 8'(i + 1);
        run_req(3'b011, 48'h0010, 1'b0);
        chk("w48_lat", last_lat, 13);
        chk("w48_read", bus.READ, 48'h0605_0403_0201);

        mem[16'h0020] = 8'h80;
        run_req(3'b100, 48'h0020, 1'b0);
        chk("sbyte", bus.READ, 48'hFFFF_FFFF_FF80);
        chk("byte_lat", last_lat, 3);
        run_req(3'b000, 48'h0020, 1'b1);
        chk("ubyte", bus.READ, 48'h0000_0000_0080);

        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        run_req(3'b101, 48'hABCD_0000_FFFF, 1'b0);
        chk("half_read", bus.READ, 48'h1234);
        chk("half_lat", last_lat, 5);
        if (re_q.size() == 2) begin
            chk("half_a0", re_q[0], 16'hFFFF);
            chk("half_a1", re_q[1], 16'h0000);
        end else begin
            chk("half_re_n", re_q.size(), 2);
        end

        wv[0] = TO - 1;
        run_req(3'b000, 48'h0021, 1'b0);
        chk("edge_ok_err", bus.ERROR, 1'b0);
        chk("edge_ok_lat", last_lat, TO + 2);
        set_waits(0);

        timeout_req(48'h0040);
        repeat (5) @(posedge clk);
        #3;
        chk("to_err_stays", bus.ERROR, 1'b1);
        run_req(3'b000, 48'h0041, 1'b0);
        chk("err_cleared", bus.ERROR, 1'b0);

        wq.delete();
        @(negedge clk);
        hs0         = hs_cnt;
        bus.CTRL    = 3'b010;
        bus.ADDRESS = 48'h0100;
        bus.ENABLE  = 1'b1;
        @(posedge clk);
        h1 = 0;
        h2 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #3;
            if (bus.HANDSHAKE) begin
                if (h1 == 0) h1 = k;
                else begin
                    h2 = k;
                    break;
                end
            end
        end
        bus.ENABLE = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        chk("held_h1", h1, 9);
        chk("held_h2", h2, 9 + HOLD + 1 + 9);
        chk("held_hs_n", hs_cnt - hs0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [2:0]  c;
            logic [47:0] a;
            c = 3'($urandom);
            a = 48'({$urandom, $urandom});
            for (int i = 0; i < 6; i++)
                wv[i] = ($urandom_range(0, 15) == 0) ? TO :
                        int'($urandom_range(0, TO - 1));
            run_req(c, a, 1'($urandom));
        end
        set_waits(0);

        timeout_req(48'h0300);
        wq.delete();
        wq.push_back(0);
        wq.push_back(3);
        @(negedge clk);
        bus.CTRL    = 3'b010;
        bus.ADDRESS = 48'h0200;
        bus.ENABLE  = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3;
        hs0 = hs_cnt;
        rst = 1'b1;
        @(posedge clk);
        #3;
        chk("abort_busy", bus.BUSY, 1'b0);
        chk("abort_read", bus.READ, 48'h0);
        chk("abort_err", bus.ERROR, 1'b0);
        chk("abort_hs", bus.HANDSHAKE, 1'b0);
        rst        = 1'b0;
        bus.ENABLE = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("abort_no_hs", hs_cnt - hs0, 0);
        run_req(3'b110, 48'h0200, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Responder end of the CPU's memory-access handshake (ENABLE/CTRL/ADDRESS in; READ/HANDSHAKE out).
- Serves load requests from the memory stage by reading a slow byte-wide external memory. It assembles 1, 2, 4 or 6 bytes into a 48-bit result, then pulses HANDSHAKE so the gated CPU clock resumes.
- Runs on the master clock, in parallel with the data RAM path.

Parameters:
- ADDR_W, 16, width of the external byte address.
- TIMEOUT, 255, maximum WAIT cycles per byte before an error response (1..255).
- HOLD_CYCLES, 2, cycles after HANDSHAKE during which ENABLE is ignored (≥1).

Ports:
- CLK  in  1  master clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  request valid, held high by the initiator until HANDSHAKE.
- CTRL  in  3  [1:0] size (00 byte, 01 half, 10 word32, 11 word48); [2] sign-extend.
- ADDRESS  in  48  byte address; only [ADDR_W-1:0] is used.
- READ  out  48  assembled, extended result.
- HANDSHAKE  out  1  one-cycle completion pulse.
- ERROR  out  1  last response timed out; valid with HANDSHAKE and held afterwards.
- BUSY  out  1  high in every state except IDLE.
- MEM_ADDR  out  ADDR_W  external byte address.
- MEM_RE  out  1  one-cycle external read strobe.
- MEM_RDATA  in  8  external read data.
- MEM_VALID  in  1  MEM_RDATA valid; sampled only in WAIT.

Behaviour:
- Reset values: READ=0, HANDSHAKE=0, ERROR=0, BUSY=0, MEM_RE=0, MEM_ADDR=0; state IDLE; counters 0.
  - Reset in any state aborts the access at the next edge. No HANDSHAKE is issued for the aborted request.
- All outputs are registered.
- State IDLE:
  - If ENABLE=1: latch CTRL and ADDRESS[ADDR_W-1:0] as base, set byte index i=0 and N = 1/2/4/6 per CTRL[1:0], then go to ISSUE.
- State ISSUE:
  - MEM_RE=1 for exactly one cycle, MEM_ADDR = base+i (mod 2^ADDR_W, so the address wraps).
  - Clear the timeout counter, then go to WAIT.
- State WAIT:
  - If MEM_VALID=1: write MEM_RDATA into byte lane i (little-endian, lane i = bits 8i+7:8i).
    - If i==N-1, go to RESP.
    - Otherwise i++ and go to ISSUE.
  - If MEM_VALID=0: increment the counter. When the counter reaches TIMEOUT, set the error flag and go to RESP.
- State RESP (one cycle):
  - HANDSHAKE=1 and READ updated in the same cycle.
  - Success: READ = the assembled N bytes. If CTRL[2]=1, upper bits are filled from bit 8N-1; otherwise they are zero-filled. N=6 gives no extension.
  - Timeout: READ = 48'hFFFF_FFFF_FFFF and ERROR=1.
  - Then go to HOLD.
- State HOLD:
  - Count HOLD_CYCLES with ENABLE ignored, then go to IDLE.
  - This gives the gated CPU clock time to advance, so a still-high ENABLE is not re-accepted as the same request.
  - Back-to-back requests are accepted in IDLE after HOLD ends.
- Latency with MEM_VALID returned in the cycle after MEM_RE:
  - Acceptance edge = cycle 0; HANDSHAKE is high in cycle 2N+1.
  - Byte → cycle 3; half → cycle 5; word32 → cycle 9; word48 → cycle 13.
  - Each wait cycle of the external memory adds one cycle.
- Hold and busy:
  - READ and ERROR hold their values until the next RESP.
  - BUSY is high from the cycle after acceptance through the end of HOLD.
- CTRL and ADDRESS changes after acceptance are ignored.
- MEM_VALID outside WAIT is ignored. MEM_VALID arriving on the same edge the counter reaches TIMEOUT counts as valid (data wins).

Decomposition:
- Package ext_mem_resp_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP, HOLD};
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - function size_to_bytes;
  - constant ERR_WORD = 48'hFFFF_FFFF_FFFF.
- Sub-module byte_gather: 48-bit lane register with a clear and a lane-indexed byte load. It outputs the extended value, which is combinational from the lanes, N and the sign flag.

Test Plan:
- Word48 read at ADDRESS 0x0010, memory bytes 0x10..0x15 = 01,02,03,04,05,06, zero-wait → HANDSHAKE in cycle 13, READ=48'h060504030201, ERROR=0, six MEM_RE pulses at addresses 0x10..0x15.
- Signed byte at 0x0020 = 0x80 → READ=48'hFFFF_FFFF_FF80; same request with CTRL[2]=0 → 48'h0000_0000_0080.
- Half read at base 0xFFFF (ADDR_W=16), bytes 0xFFFF=0x34 and 0x0000=0x12 → MEM_ADDR sequence FFFF then 0000, READ=48'h1234.
- TIMEOUT=4 with MEM_VALID never asserted → HANDSHAKE 6 cycles after acceptance (ISSUE+4 WAIT+RESP), READ=all ones, ERROR=1; ERROR stays 1 until the next successful RESP, which clears it.
- ENABLE held high continuously across two word32 reads → second acceptance only after HOLD_CYCLES=2; exactly two HANDSHAKE pulses.
- RESET asserted in WAIT of byte 2 → next edge IDLE, BUSY=0, READ=0, no HANDSHAKE; a new request afterwards completes normally.
